mem_responder: RTL and testbench

- Memory-side responder for the npc core's data and instruction port. It is the slave end of the load/store path, replacing the DPI pmem calls with a synthesizable SRAM model.
- Accepts one request at a time over a valid/ready request channel.
- Performs a byte-masked write or a word read after a programmable latency.
- Returns the result on a valid/ready response channel.

---
 rtl/mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: synthesizable SRAM slave for the npc load/store path.
// One request at a time: a valid/ready request channel, a programmable wait,
// then a single commit edge that does the byte-masked write or the word read,
// and finally a response held on a valid/ready response channel.
// Optional build macro MEM_RAND_LAT_EN adds 0..3 pseudo-random extra wait
// cycles per request, taken from an 8-bit LFSR.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// WAIT  | request captured, counting down the latency
// RESP  | result registered, rsp_valid=1 until the handshake

module mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        cap_wen_q, cap_wen_d;
  logic [31:0] cap_addr_q, cap_addr_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic [3:0]  cap_wmask_q, cap_wmask_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        commit;
  logic        c_wen;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_wmask;
  logic [31:0] offset;
  logic [31:0] word_off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [4:0]  eff_lat;

  assign accept    = (state_q == IDLE) && req_valid;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef MEM_RAND_LAT_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR (taps 8,6,5,4), stepped once per accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 8'hA5;
    else if (accept) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign eff_lat = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
`else
  assign eff_lat = 5'(LATENCY);
`endif

  // Commit operands: with zero wait the request commits on its own accept
  // edge, so the live inputs are used; otherwise the captured copy is.
  always_comb begin
    c_wen   = cap_wen_q;
    c_addr  = cap_addr_q;
    c_wdata = cap_wdata_q;
    c_wmask = cap_wmask_q;
    if (state_q == IDLE) begin
      c_wen   = req_wen;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wmask = req_wmask;
    end
  end

  // Range check on the word offset: an address below BASE_ADDR wraps high
  // and therefore falls out of range without a separate lower-bound test.
  assign offset    = c_addr - BASE_ADDR;
  assign word_off  = offset >> 2;
  assign in_range  = (word_off < 32'(DEPTH));
  assign idx       = word_off[AW-1:0];
  assign mem_rdata = mem[idx];
  assign mem_we    = commit && c_wen && in_range && reset;

  // Next-state, capture and commit-result logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_wen_d   = cap_wen_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_wmask_d = cap_wmask_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cap_wen_d   = req_wen;
          cap_addr_d  = req_addr;
          cap_wdata_d = req_wdata;
          cap_wmask_d = req_wmask;
          cnt_d       = eff_lat;
          if (eff_lat == 5'd0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 5'd1) begin
          commit  = 1'b1;
          cnt_d   = 5'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      rsp_err_d   = !in_range;
      rsp_rdata_d = (in_range && !c_wen) ? mem_rdata : 32'h0;
    end
  end

  // Control and response registers; storage is deliberately not reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      cap_wen_q   <= 1'b0;
      cap_addr_q  <= 32'h0;
      cap_wdata_q <= 32'h0;
      cap_wmask_q <= 4'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_wen_q   <= cap_wen_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_wmask_q <= cap_wmask_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane write into the SRAM array on the commit edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (c_wmask[b]) mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (LATENCY=1 and LATENCY=4),
// directed steps plus a randomized phase checked against a word-addressed
// reference memory.
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT0  = 1;
  localparam int          LAT1  = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [int];

  mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte address range test in 64-bit arithmetic, word store keyed by instance.
  function automatic void model_op(input int sel, input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wmask,
                                   output logic err, output logic [31:0] rdata);
    longint unsigned a;
    longint unsigned lo;
    longint unsigned hi;
    int key;
    logic [31:0] w;
    a  = 64'(addr);
    lo = 64'(BASE);
    hi = lo + 64'(4 * DEPTH);
    err = !(a >= lo && a < hi);
    rdata = 32'h0;
    if (!err) begin
      key = sel * DEPTH + int'((a - lo) / 4);
      w = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
      if (wen) begin
        for (int b = 0; b < 4; b++) if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mdl[key] = w;
      end else begin
        rdata = w;
      end
    end
  endfunction

  // Starts and ends at a falling edge.
  task automatic txn(input int sel, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask,
                     input int hold, input bit early, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] held;
    int n;
    int lat;
    lat = (sel == 0) ? LAT0 : LAT1;
    model_op(sel, wen, addr, wdata, wmask, exp_err, exp_rd);
    check("req_ready_idle", 32'(req_ready[sel]), 32'd1);
    req_valid[sel] = 1'b1;
    req_wen[sel]   = wen;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    req_wmask[sel] = wmask;
    rsp_ready[sel] = 1'b0;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    req_wen[sel]   = 1'($urandom_range(0, 1));
    req_addr[sel]  = $urandom;
    req_wdata[sel] = $urandom;
    req_wmask[sel] = 4'($urandom);
    rsp_ready[sel] = early;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[sel] && n < 40);
`ifdef MEM_RAND_LAT_EN
    check("latency_range", 32'(n >= lat + 1 && n <= lat + 4), 32'd1);
`else
    check("latency", 32'(n), 32'(lat + 1));
`endif
    check("req_ready_busy", 32'(req_ready[sel]), 32'd0);
    check("rsp_err", 32'(rsp_err[sel]), 32'(exp_err));
    check("rsp_rdata", rsp_rdata[sel], exp_rd);
    got = rsp_rdata[sel];
    if (!early) begin
      held = rsp_rdata[sel];
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid[sel]), 32'd1);
        check("hold_rdata", rsp_rdata[sel], held);
        check("hold_req_ready", 32'(req_ready[sel]), 32'd0);
      end
      rsp_ready[sel] = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", 32'(rsp_valid[sel]), 32'd0);
    check("post_req_ready", 32'(req_ready[sel]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        w;
    int r;
    int s;
    int hold;
    bit early;

    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b0; req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; req_wmask[i] = 4'h0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'h0);
      check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    @(negedge clk);

    // Full-word write, read back.
    txn(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, got);
    txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, got);
    check("rd_deadbeef", got, 32'hDEAD_BEEF);

    // Single byte lane over an existing word.
    txn(0, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF, 0, 1'b0, got);
    txn(0, 1'b1, 32'h8000_0005, 32'h0000_AB00, 4'b0010, 0, 1'b1, got);
    txn(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, 1'b0, got);
    check("rd_bytelane", got, 32'h1122_AB44);

    // Out of range both sides, word 0 untouched.
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b0, got);
    txn(0, 1'b1, 32'h8000_1000, 32'h5555_AAAA, 4'hF, 0, 1'b0, got);
    txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, got);
    check("rd_word0_after_oor", got, 32'hDEAD_BEEF);

    // Top word in range; zero-mask write is a no-op.
    txn(0, 1'b1, 32'h8000_0FFC, 32'h0F0F_1234, 4'hF, 0, 1'b0, got);
    txn(0, 1'b0, 32'h8000_0FFF, 32'h0, 4'h0, 0, 1'b0, got);
    check("rd_top_word", got, 32'h0F0F_1234);
    txn(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, got);
    txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, got);

    // Backpressure: response held 5 cycles.
    txn(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 5, 1'b0, got);

    // Randomized phase over a 16-word pool at both ends of the array.
    for (int i = 0; i < 16; i++) begin
      s = (i < 8) ? i : 1008 + i;
      txn(0, 1'b1, BASE + 32'(4 * s), $urandom, 4'hF, 0, 1'b0, got);
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      s = $urandom_range(0, 15);
      s = (s < 8) ? s : 1008 + s;
      if (r == 0)      a = 32'h7FFF_FFFC - 32'(4 * $urandom_range(0, 3));
      else if (r == 1) a = 32'h8000_1000 + 32'($urandom_range(0, 255));
      else             a = BASE + 32'(4 * s) + 32'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      m = 4'($urandom);
      hold = $urandom_range(0, 3);
      early = (hold == 0) && ($urandom_range(0, 1) == 1);
      txn(0, w, a, d, m, hold, early, got);
    end

    // LATENCY=4 instance: normal write, then reset while in WAIT.
    txn(1, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, 1'b0, got);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0010;
    req_wdata[1] = 32'h0BAD_C0DE; req_wmask[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    reset[1] = 1'b0;
    #1;
    check("midwait_rst_valid", 32'(rsp_valid[1]), 32'd0);
    check("midwait_rst_ready", 32'(req_ready[1]), 32'd1);
    repeat (3) @(negedge clk);
    check("midwait_rst_rdata", rsp_rdata[1], 32'h0);
    reset[1] = 1'b1;
    @(negedge clk);
    txn(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 1'b0, got);
    check("rd_after_aborted_write", got, 32'hCAFE_F00D);
    txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, 1'b0, got);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
